// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, default debounce/long-press windows and 4-input priority encoder for key_debounce
package key_pkg;
  typedef enum logic [1:0] {IDLE, P_WAIT, PRESSED, R_WAIT} key_state_t;
  localparam int unsigned DB_T_DEF = 1000000;
  localparam int unsigned LP_T_DEF = 50000000;
  function automatic logic [1:0] prio_enc4(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/key_db_cell.sv
// key_db_cell: one key's 2-flop sync, debounce FSM and optional long-press counter (KEY_LONGPRESS_EN); ports sys_clk, sys_rst_n, key_in (0=pressed) -> key_level, key_press, key_release, key_long, press_nxt (unregistered press for the top's key_valid/key_code)
module key_db_cell
  import key_pkg::*;
#(
  parameter int unsigned DB_T = DB_T_DEF,
  parameter int unsigned LP_T = LP_T_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic press_nxt
);
  localparam logic [31:0] DB_M1 = 32'(DB_T - 1);
  logic s1, s2, level_n, release_n;
  key_state_t state, state_n;
  logic [31:0] cnt, cnt_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_in;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      key_level   <= level_n;
      key_press   <= press_nxt;
      key_release <= release_n;
    end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = key_level;
    press_nxt = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE:    if (!s2) begin state_n = P_WAIT; cnt_n = '0; end
      P_WAIT:  if (s2) state_n = IDLE;
               else if (cnt == DB_M1) begin state_n = PRESSED; press_nxt = 1'b1; level_n = 1'b1; end
               else cnt_n = cnt + 32'd1;
      PRESSED: if (s2) begin state_n = R_WAIT; cnt_n = '0; end
      R_WAIT:  if (!s2) state_n = PRESSED;
               else if (cnt == DB_M1) begin state_n = IDLE; release_n = 1'b1; level_n = 1'b0; end
               else cnt_n = cnt + 32'd1;
      default: state_n = IDLE;
    endcase
  end
`ifdef KEY_LONGPRESS_EN
  localparam logic [31:0] LP_M1 = 32'(LP_T - 1);
  localparam logic [31:0] LP_FRZ = 32'(LP_T);
  logic [31:0] lp_cnt;
  logic in_pressed;
  assign in_pressed = state == PRESSED;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      lp_cnt   <= '0;
      key_long <= 1'b0;
    end else begin
      lp_cnt   <= press_nxt ? '0 :
                  in_pressed && lp_cnt < LP_M1 ? lp_cnt + 32'd1 :
                  in_pressed && lp_cnt == LP_M1 ? LP_FRZ : lp_cnt;
      key_long <= in_pressed && lp_cnt == LP_M1;
    end
`else
  logic [31:0] unused_lp;
  assign unused_lp = 32'(LP_T);
  assign key_long  = 1'b0;
`endif
endmodule

// File: rtl/key_debounce.sv
// key_debounce: KEY_NUM active-low buttons synchronised/debounced into levels, press/release/long pulses (long needs KEY_LONGPRESS_EN) plus key_valid/key_code; ports sys_clk, sys_rst_n, key_in -> key_level, key_press, key_release, key_valid, key_code, key_long
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM = 4,
  parameter int unsigned DB_T    = DB_T_DEF,
  parameter int unsigned LP_T    = LP_T_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic               key_valid,
  output logic [1:0]         key_code,
  output logic [KEY_NUM-1:0] key_long
);
  logic [KEY_NUM-1:0] press_nxt;
  logic [3:0] press4;
  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    key_db_cell #(.DB_T(DB_T), .LP_T(LP_T)) u_cell (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in[k]),
      .key_level  (key_level[k]),
      .key_press  (key_press[k]),
      .key_release(key_release[k]),
      .key_long   (key_long[k]),
      .press_nxt  (press_nxt[k])
    );
  end
  assign press4 = 4'(press_nxt);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 2'd0;
    end else begin
      key_valid <= |press4;
      key_code  <= |press4 ? prio_enc4(press4) : key_code;
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table vectors, directed corner sequences and random stimulus against a run-length reference model
module tb_key_debounce;
  localparam int DB = 16;
  localparam int LP = 64;
`ifdef KEY_LONGPRESS_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif
  logic sys_clk = 1'b0, sys_rst_n = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_long;
  logic key_valid;
  logic [1:0] key_code;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  key_debounce #(.KEY_NUM(4), .DB_T(DB), .LP_T(LP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_valid(key_valid), .key_code(key_code), .key_long(key_long)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  // reference: a key toggles once its synchronised input has disagreed with the level for DB+1 edges
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
  logic m_valid = 1'b0;
  logic [1:0] m_code = '0;
  int run[4] = '{default: 0};
  int held[4] = '{default: 0};
  bit fired[4] = '{default: 1'b0};
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      m_valid = 1'b0; m_code = '0;
      for (int i = 0; i < 4; i++) begin run[i] = 0; held[i] = 0; fired[i] = 1'b0; end
    end else begin
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < 4; i++) begin
        if (LONG && m_level[i] && run[i] == 0 && !fired[i]) begin
          held[i]++;
          if (held[i] == LP) begin m_long[i] = 1'b1; fired[i] = 1'b1; end
        end
        run[i] = (m_s2[i] == m_level[i]) ? run[i] + 1 : 0;
        if (run[i] == DB + 1) begin
          run[i] = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin m_press[i] = 1'b1; held[i] = 0; fired[i] = 1'b0; end
          else m_rel[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_in;
      m_valid = |m_press;
      if (m_valid) for (int i = 3; i >= 0; i--) if (m_press[i]) m_code = 2'(i);
    end
  always @(negedge sys_clk)
    if (chk_en)
      check("model_outputs", {13'd0, key_level, key_press, key_release, key_long, key_valid, key_code},
            {13'd0, m_level, m_press, m_rel, m_long, m_valid, m_code});
  typedef struct {logic [3:0] key; int cyc; logic [3:0] exp_level;} vec_t;
  vec_t vecs[10];
  int pe, le, nl;
  bit seen;
  int hold[4];
  initial begin
    vecs[0] = '{4'b1110, 30, 4'b0001};
    vecs[1] = '{4'b1111, 10, 4'b0001};
    vecs[2] = '{4'b1111, 20, 4'b0000};
    vecs[3] = '{4'b0011, 5,  4'b0000};
    vecs[4] = '{4'b0011, 20, 4'b1100};
    vecs[5] = '{4'b1011, 25, 4'b0100};
    vecs[6] = '{4'b1111, 25, 4'b0000};
    vecs[7] = '{4'b0000, 19, 4'b1111};
    vecs[8] = '{4'b1111, 18, 4'b1111};
    vecs[9] = '{4'b1111, 1,  4'b0000};
    #1 sys_rst_n = 1'b0;
    #1 check("reset_outputs", {key_level, key_press, key_release, key_long, key_valid, key_code}, '0);
    tick(2);
    sys_rst_n = 1'b1;
    chk_en = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      key_in = vecs[i].key;
      tick(vecs[i].cyc);
      check($sformatf("vec%0d_level", i), {28'd0, key_level}, {28'd0, vecs[i].exp_level});
    end
    // clean press of key 2
    key_in = 4'b1011;
    tick(18);
    check("clean_press_early", {28'd0, key_press}, 32'd0);
    tick(1);
    check("clean_press", {25'd0, key_press, key_valid, key_code}, {25'd0, 4'b0100, 1'b1, 2'd2});
    tick(1);
    check("clean_after", {25'd0, key_press, key_valid, key_level[2], key_code}, {25'd0, 4'b0000, 1'b0, 1'b1, 2'd2});
    key_in = 4'hF;
    tick(25);
    // bounce rejection on key 0
    seen = 1'b0;
    key_in = 4'b1110;
    for (int i = 0; i < 10; i++) begin tick(1); seen |= key_press[0]; end
    key_in = 4'hF;
    for (int i = 0; i < 3; i++) begin tick(1); seen |= key_press[0]; end
    key_in = 4'b1110;
    for (int i = 0; i < 10; i++) begin tick(1); seen |= key_press[0]; end
    key_in = 4'hF;
    for (int i = 0; i < 20; i++) begin tick(1); seen |= key_press[0] | key_level[0]; end
    check("bounce_no_press", {31'd0, seen}, 32'd0);
    key_in = 4'b1110;
    tick(20);
    check("bounce_then_hold", {31'd0, key_level[0]}, 32'd1);
    // release bounce on key 0 (still held)
    seen = 1'b0;
    key_in = 4'hF;
    for (int i = 0; i < 8; i++) begin tick(1); seen |= key_press[0] | key_release[0]; end
    key_in = 4'b1110;
    for (int i = 0; i < 2; i++) begin tick(1); seen |= key_press[0] | key_release[0]; end
    key_in = 4'hF;
    for (int i = 0; i < 18; i++) begin tick(1); seen |= key_press[0] | key_release[0]; end
    check("rel_bounce_quiet", {31'd0, seen}, 32'd0);
    tick(1);
    check("rel_bounce_pulse", {28'd0, key_release}, {28'd0, 4'b0001});
    tick(20);
    // simultaneous press of keys 3 and 1
    key_in = 4'b0101;
    tick(19);
    check("simul_press", {25'd0, key_press, key_valid, key_code}, {25'd0, 4'b1010, 1'b1, 2'd1});
    key_in = 4'hF;
    tick(25);
    // reset in the middle of key 1's press debounce
    key_in = 4'b1101;
    tick(11);
    #2 sys_rst_n = 1'b0;
    #1 check("midreset_zero", {key_level, key_press, key_release, key_long, key_valid, key_code}, '0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    tick(18);
    check("midreset_early", {28'd0, key_press}, 32'd0);
    tick(1);
    check("midreset_press", {28'd0, key_press}, {28'd0, 4'b0010});
    key_in = 4'hF;
    tick(25);
    // long press of key 3
    pe = -1; le = -1; nl = 0;
    key_in = 4'b0111;
    for (int e = 1; e <= 200; e++) begin
      tick(1);
      if (key_press[3]) pe = e;
      if (key_long != 4'b0000) begin nl++; le = e; end
    end
    check("long_count", nl, LONG ? 32'd1 : 32'd0);
    if (LONG) check("long_delay", le - pe, LP);
    key_in = 4'hF;
    tick(25);
    // random stimulus with mixed short bounces and long holds
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if (hold[i] == 0) begin
          key_in[i] = ~key_in[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(10, 60));
        end else hold[i]--;
      tick(1);
    end
    key_in = 4'hF;
    tick(30);
    check("final_idle", {28'd0, key_level}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side companion to the board LED pattern driver.
- Samples KEY_NUM raw active-low push buttons, synchronises and debounces each one, and emits one-cycle press/release event pulses plus stable levels.
- Sits between the board key pins and the pattern/mode control logic; all outputs are in the sys_clk domain.

Parameters:
- KEY_NUM, 4, number of push buttons
- DB_T, 1000000, debounce window in sys_clk cycles (20 ms at 50 MHz); must be >= 2
- LP_T, 50000000, long-press threshold in sys_clk cycles, counted from press acceptance; used only with the optional feature

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- key_in  input  KEY_NUM  raw button pins; 0 = pressed
- key_level  output  KEY_NUM  debounced level; 1 = pressed
- key_press  output  KEY_NUM  one-cycle pulse per accepted press
- key_release  output  KEY_NUM  one-cycle pulse per accepted release
- key_valid  output  1  one-cycle pulse; at least one key_press bit is set this cycle
- key_code  output  2  index of the lowest-numbered key_press bit; valid with key_valid
- key_long  output  KEY_NUM  one-cycle long-press pulse; constant 0 without the macro

Behaviour:
- Reset (asynchronous, sys_rst_n = 0): all outputs 0. Synchroniser flops preset to 1 (released). All FSMs go to IDLE. All counters clear to 0.
- Each key_in bit passes through a 2-flop synchroniser (s1, s2). The FSM sees only s2.
- Per-key FSM with 32-bit counter cnt:
  - IDLE: s2 = 0 -> P_WAIT, cnt <= 0.
  - P_WAIT: s2 = 1 -> IDLE (glitch rejected, no pulse). cnt == DB_T-1 -> PRESSED, key_press pulse, key_level <= 1. Otherwise cnt++.
  - PRESSED: s2 = 1 -> R_WAIT, cnt <= 0.
  - R_WAIT: s2 = 0 -> PRESSED (bounce, no pulse, level stays 1). cnt == DB_T-1 -> IDLE, key_release pulse, key_level <= 0. Otherwise cnt++.
- Latency: key_in is first sampled low at edge 1 and held low. P_WAIT is entered at edge 3, and key_press is high for exactly the cycle after edge DB_T+3. Release timing is symmetric.
- Any bounce shorter than DB_T consecutive stable cycles produces no event.
- key_press and key_release are never both high for the same key. A new press requires a full release first.
- key_valid = OR of key_press, registered with the pulses in the same cycle.
- key_code is a priority encode, lowest index wins. Other simultaneous presses appear only in the key_press vector.
- key_code holds its last value when key_valid = 0; it is 0 after reset.
- Counters saturate by state change and never wrap. cnt width is 32 bits, so DB_T and LP_T must each be <= 2^32.
- Reset asserted mid-debounce aborts immediately and emits no pulse. After reset is released, a key still held down must pass the full press debounce again.

Optional Feature:
- Macro: KEY_LONGPRESS_EN.
- Defined: PRESSED keeps a second counter lp_cnt, cleared on entry from P_WAIT only; a return from R_WAIT does not clear it.
  - When lp_cnt == LP_T-1, key_long pulses for one cycle.
  - It fires at most once per press; lp_cnt freezes until release is accepted.
- Undefined: no lp_cnt logic; key_long is tied to 0.

Decomposition:
- Shared package key_pkg holds:
  - key_state_t enum {IDLE, P_WAIT, PRESSED, R_WAIT}, 2-bit encoding 0..3
  - default constants DB_T_DEF = 1000000 and LP_T_DEF = 50000000
  - helper function prio_enc4
- Sub-module key_db_cell contains one key's synchroniser, FSM, counter and optional long-press counter. The top instantiates it KEY_NUM times in a generate loop and adds the priority encoder plus the key_valid/key_code registers.

Test Plan (DB_T = 16, LP_T = 64):
- Clean press: key_in[2] goes 1->0 and is held -> key_press = 4'b0100 and key_valid = 1 for exactly one cycle after edge 19; key_code = 2; key_level[2] = 1 from then on.
- Bounce reject: key_in[0] low 10 cycles, high 3, low 10, then high -> no key_press, key_level stays 0. Holding low 16+ cycles then produces the press.
- Simultaneous press: key_in[3] and key_in[1] fall on the same edge -> key_press = 4'b1010 in one cycle, key_code = 1.
- Release bounce: key 0 is pressed, key_in[0] goes high 8 cycles, low 2, then high -> a single key_release pulse 16 stable-high cycles (+2 synchroniser) after the final rise; no second press pulse.
- Reset mid-debounce: key_in[1] low, sys_rst_n pulsed low at cycle 8 of P_WAIT -> all outputs 0 immediately. With key_in[1] held low, key_press[1] fires 19 edges after reset release.
- Long press (KEY_LONGPRESS_EN): key 3 held 200 cycles -> exactly one key_long[3] pulse 64 cycles after key_press[3]. Without the macro, key_long stays 4'b0000.
